// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: register-number width, the hard-wired zero
// register and the state encoding of the multiply/divide occupancy tracker.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_muldiv_tracker.sv
// Tracks occupancy of the multi-cycle multiply/divide unit.
// busy is high for exactly MULDIV_LAT cycles after an accepted start edge.
// A start while busy is ignored, except in the final busy cycle, where it is
// accepted so that operations can run back to back.
// Only instantiated when PIPE_HAZARD_MULDIV_EN is defined.
module muldiv_tracker
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy
);

  localparam int CW = $clog2(MULDIV_LAT);
  localparam logic [CW-1:0] RELOAD = CW'(MULDIV_LAT - 1);

  md_state_t     state;
  md_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // State and down-counter registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: load on accepted start, count down while busy
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MD_IDLE: begin
        if (start) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = RELOAD;
        end
      end
      MD_BUSY: begin
        if (cnt == '0) begin
          if (start) begin
            state_nxt = MD_BUSY;
            cnt_nxt   = RELOAD;
          end else begin
            state_nxt = MD_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and multiply/divide stall detection,
// taken-branch flush, and a saturating stall-cycle counter.
// Define PIPE_HAZARD_MULDIV_EN to include the multiply/divide busy tracker;
// without it muldiv_busy is tied low and the HI/LO hazard never fires.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reads_hilo,
  input  logic             id_is_muldiv,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_muldiv_start,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic load_use;
  logic md_hazard;

`ifdef PIPE_HAZARD_MULDIV_EN
  muldiv_tracker #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_muldiv_tracker (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (ex_muldiv_start),
    .busy   (muldiv_busy)
  );

  assign md_hazard = muldiv_busy && (id_reads_hilo || id_is_muldiv);
`else
  localparam int unused_muldiv_lat = MULDIV_LAT;
  logic unused_muldiv_inputs;

  assign unused_muldiv_inputs = ^{ex_muldiv_start, id_reads_hilo, id_is_muldiv};
  assign muldiv_busy          = 1'b0;
  assign md_hazard            = 1'b0;
`endif

  assign load_use = ex_memread && (ex_rd != REG_ZERO) &&
                    ((id_uses_rs && (id_rs == ex_rd)) ||
                     (id_uses_rt && (id_rt == ex_rd)));

  // Control decode: a taken branch wins over any stall; stalls are held off during reset
  always_comb begin
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (ex_branch_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (reset_n && (load_use || md_hazard)) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall_pc && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a vector table for the hazard
// decode, hand sequences for the multiply/divide tracker, reset mid-operation
// and counter saturation (second instance with CNT_W=4).
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_reads_hilo, id_is_muldiv;
  logic       ex_memread, ex_branch_taken, ex_muldiv_start;
  logic       stall_pc, stall_ifid, flush_ifid, flush_idex, muldiv_busy;
  logic [15:0] stall_cnt;
  logic       stall_pc4, stall_ifid4, flush_ifid4, flush_idex4, muldiv_busy4;
  logic [3:0] stall_cnt4;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, rd;
    logic       uses_rs, uses_rt, hilo, ismd, memread, br, start;
    logic       spc, sifid, fifid, fidex, busy;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  outs;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [15:0] model_cnt = '0;
  logic [3:0]  model_cnt4 = '0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULDIV_LAT(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reads_hilo(id_reads_hilo), .id_is_muldiv(id_is_muldiv),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_muldiv_start(ex_muldiv_start), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .muldiv_busy(muldiv_busy),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MULDIV_LAT(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reads_hilo(id_reads_hilo), .id_is_muldiv(id_is_muldiv),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_muldiv_start(ex_muldiv_start), .stall_pc(stall_pc4), .stall_ifid(stall_ifid4),
    .flush_ifid(flush_ifid4), .flush_idex(flush_idex4), .muldiv_busy(muldiv_busy4),
    .stall_cnt(stall_cnt4)
  );

  function automatic vec_t mk(string name, logic [4:0] rs, logic urs, logic [4:0] rt,
                              logic urt, logic mr, logic [4:0] rd, logic br,
                              logic hilo, logic ismd, logic start, logic [4:0] outs);
    vec_t v;
    v.name = name; v.rs = rs; v.uses_rs = urs; v.rt = rt; v.uses_rt = urt;
    v.memread = mr; v.rd = rd; v.br = br; v.hilo = hilo; v.ismd = ismd; v.start = start;
    {v.spc, v.sifid, v.fifid, v.fidex, v.busy} = outs;
    return v;
  endfunction

  // Drive one cycle of inputs just after the edge and queue what must come out
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
    id_reads_hilo = v.hilo; id_is_muldiv = v.ismd; ex_memread = v.memread;
    ex_rd = v.rd; ex_branch_taken = v.br; ex_muldiv_start = v.start;
    e.name = v.name;
    e.outs = {v.spc, v.sifid, v.fifid, v.fidex, v.busy};
    e.cnt  = model_cnt;
    e.cnt4 = model_cnt4;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare on the falling edge
  task automatic checkOutput();
    exp_t e;
    logic [4:0] got;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("[TB] FAIL scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    got = {stall_pc, stall_ifid, flush_ifid, flush_idex, muldiv_busy};
    n_vec++;
    if (got !== e.outs) begin
      n_err++;
      $display("[TB] FAIL %s ctrl {spc,sifid,fifid,fidex,busy} got=%b exp=%b", e.name, got, e.outs);
    end
    n_vec++;
    if (stall_cnt !== e.cnt) begin
      n_err++;
      $display("[TB] FAIL %s stall_cnt got=%0d exp=%0d", e.name, stall_cnt, e.cnt);
    end
    n_vec++;
    if (stall_cnt4 !== e.cnt4) begin
      n_err++;
      $display("[TB] FAIL %s stall_cnt4 got=%0d exp=%0d", e.name, stall_cnt4, e.cnt4);
    end
    if (e.outs[4]) begin
      if (model_cnt != 16'hFFFF) model_cnt++;
      if (model_cnt4 != 4'hF) model_cnt4++;
    end
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  vec_t table_v[$];
  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] STALL = 5'b11010;
  localparam logic [4:0] FLUSH = 5'b00110;

  initial begin
    logic [4:0] md_stall;
    logic [4:0] md_idle_busy;
    reset_n = 1'b0;
    id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_reads_hilo = 0; id_is_muldiv = 0; ex_memread = 0; ex_branch_taken = 0;
    ex_muldiv_start = 0;

    // reset behaviour: outputs quiet, stalls suppressed, branch still flushes
    runVec(mk("rst_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    runVec(mk("rst_loaduse",  7, 1, 0, 0, 1, 7, 0, 0, 0, 0, NONE));
    runVec(mk("rst_branch",   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FLUSH));
    reset_n = 1'b1;

    table_v.push_back(mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    table_v.push_back(mk("lu_rs",       7, 1, 0, 0, 1, 7, 0, 0, 0, 0, STALL));
    table_v.push_back(mk("zero_reg",    0, 1, 0, 0, 1, 0, 0, 0, 0, 0, NONE));
    table_v.push_back(mk("br_prio",     7, 1, 0, 0, 1, 7, 1, 0, 0, 0, FLUSH));
    table_v.push_back(mk("lu_rt",       0, 0, 12, 1, 1, 12, 0, 0, 0, 0, STALL));
    table_v.push_back(mk("rt_unused",   0, 0, 12, 0, 1, 12, 0, 0, 0, 0, NONE));
    table_v.push_back(mk("no_load",     7, 1, 0, 0, 0, 7, 0, 0, 0, 0, NONE));
    table_v.push_back(mk("rs_differs",  8, 1, 0, 0, 1, 7, 0, 0, 0, 0, NONE));
    table_v.push_back(mk("branch",      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FLUSH));
    table_v.push_back(mk("lu_rt31",     3, 1, 31, 1, 1, 31, 0, 0, 0, 0, STALL));
    table_v.push_back(mk("hilo_idle",   0, 0, 0, 0, 0, 0, 0, 1, 1, 0, NONE));
    table_v.push_back(mk("zero_rt",     0, 0, 0, 1, 1, 0, 0, 0, 0, 0, NONE));
    foreach (table_v[i]) runVec(table_v[i]);

    // muldiv: start, hold HI/LO read; restart at busy cycle 3 ignored,
    // restart at busy cycle 8 accepted for back-to-back operation
    md_stall     = MD_EN ? 5'b11011 : NONE;
    md_idle_busy = NONE;
    runVec(mk("md_start", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, md_idle_busy));
    for (int k = 1; k <= 16; k++)
      runVec(mk($sformatf("md_busy%0d", k), 0, 0, 0, 0, 0, 0, 0, 1, 0,
                (k == 3 || k == 8) ? 1'b1 : 1'b0, md_stall));
    runVec(mk("md_done", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NONE));

    // reset in the middle of an operation, between clock edges
    runVec(mk("md2_start", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, NONE));
    for (int k = 1; k <= 4; k++)
      runVec(mk($sformatf("md2_busy%0d", k), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, md_stall));
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (muldiv_busy !== 1'b0 || stall_cnt !== '0 || stall_cnt4 !== '0) begin
      n_err++;
      $display("[TB] FAIL midop_reset busy=%b cnt=%0d cnt4=%0d exp busy=0 cnt=0 cnt4=0",
               muldiv_busy, stall_cnt, stall_cnt4);
    end
    model_cnt  = '0;
    model_cnt4 = '0;
    reset_n = 1'b1;
    runVec(mk("after_reset", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NONE));

    // saturation of the 4-bit counter under a held load-use
    for (int k = 0; k < 20; k++)
      runVec(mk($sformatf("sat%0d", k), 9, 1, 0, 0, 1, 9, 0, 0, 0, 0, STALL));
    runVec(mk("sat_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    n_vec++;
    if (stall_cnt4 !== 4'd15) begin
      n_err++;
      $display("[TB] FAIL sat_final stall_cnt4 got=%0d exp=15", stall_cnt4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_LAT, default 8, meaning the number of busy cycles of the multi-cycle multiply/divide unit (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall-cycle performance counter.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt.
REQ-007 id_reads_hilo  in  1  ID instruction reads HI/LO (MFHI/MFLO).
REQ-008 id_is_muldiv  in  1  ID instruction is a MULT/DIV.
REQ-009 ex_memread  in  1  EX instruction is a load.
REQ-010 ex_rd  in  5  destination register of the EX instruction.
REQ-011 ex_branch_taken  in  1  EX resolved a taken branch or jump.
REQ-012 ex_muldiv_start  in  1  EX instruction launches a MULT/DIV this cycle.
REQ-013 stall_pc, stall_ifid  out  1 each  hold the PC and the IF/ID pipeline register.
REQ-014 flush_ifid, flush_idex  out  1 each  drive the reset input of the IF/ID and ID/EX pipeline registers, clearing them to a bubble.
REQ-015 muldiv_busy  out  1  multiply/divide unit is occupied.
REQ-016 stall_cnt  out  CNT_W  number of cycles in which stall_pc was asserted, saturating.

Function
REQ-017 load_use SHALL be ex_memread && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
REQ-018 md_hazard SHALL be muldiv_busy && (id_reads_hilo || id_is_muldiv).
REQ-019 If ex_branch_taken is high, the block SHALL drive flush_ifid=1, flush_idex=1, stall_pc=0 and stall_ifid=0, regardless of load_use or md_hazard.
REQ-020 Otherwise, if load_use or md_hazard is high, the block SHALL drive stall_pc=1, stall_ifid=1, flush_idex=1 and flush_ifid=0.
REQ-021 Otherwise, all four control outputs SHALL be 0.
REQ-022 The control outputs SHALL be combinational from the inputs and the current FSM state, with zero-cycle latency, so that the pipeline registers sample them at the same posedge.
REQ-023 The FSM SHALL have states IDLE and BUSY, with a down-counter of width clog2(MULDIV_LAT).
REQ-024 IDLE to BUSY: ex_muldiv_start=1 at a posedge; the counter loads MULDIV_LAT-1.
REQ-025 BUSY: the counter decrements each cycle; at counter==0 the FSM returns to IDLE at the next posedge.
REQ-026 muldiv_busy SHALL be high exactly MULDIV_LAT cycles after the start edge.
REQ-027 ex_muldiv_start while in BUSY SHALL be ignored: no restart and no counter reload.
REQ-028 ex_muldiv_start in the cycle in which BUSY exits (counter==0) SHALL be accepted and reload the counter, giving back-to-back operation.
REQ-029 ex_branch_taken SHALL NOT abort a BUSY operation.
REQ-030 stall_cnt SHALL increment by 1 at every posedge where stall_pc=1, and SHALL saturate at all-ones without wrapping.

Reset
REQ-031 reset_n=0 SHALL immediately force the FSM to IDLE, the counter to 0, stall_cnt to 0 and muldiv_busy to 0, with no clock required.
REQ-032 During reset, all control outputs SHALL be 0 unless ex_branch_taken is high.
REQ-033 A reset asserted mid-BUSY SHALL abandon the operation.
REQ-034 After deassertion of reset_n, the first posedge SHALL behave as from IDLE.

Configuration
REQ-035 With macro PIPE_HAZARD_MULDIV_EN defined, the FSM, muldiv_busy and md_hazard SHALL be present as specified above.
REQ-036 Without PIPE_HAZARD_MULDIV_EN, the FSM and counter SHALL be absent, muldiv_busy SHALL be tied to 0, md_hazard SHALL be 0, and ex_muldiv_start, id_reads_hilo and id_is_muldiv SHALL be ignored.

Structure
REQ-037 A shared pipeline package SHALL hold the register-number width (5), the zero-register constant and the muldiv FSM state enum.
REQ-038 The muldiv FSM plus counter SHALL be a single sub-module, muldiv_tracker, instantiated only under PIPE_HAZARD_MULDIV_EN.
REQ-039 The hazard decode and the stall counter SHALL live in the top module.

Verification
REQ-040 Load-use: ex_memread=1, ex_rd=7, id_rs=7, id_uses_rs=1 -> stall_pc=stall_ifid=flush_idex=1 and flush_ifid=0; stall_cnt +1 at the next edge.
REQ-041 Zero register: same as REQ-040 with ex_rd=0, id_rs=0 -> all control outputs 0.
REQ-042 Branch priority: load_use condition true and ex_branch_taken=1 -> flush_ifid=flush_idex=1, stall_pc=0, and stall_cnt unchanged.
REQ-043 Muldiv: MULDIV_LAT=8, pulse ex_muldiv_start, then hold id_reads_hilo=1 -> muldiv_busy and stall_pc high for exactly 8 cycles, then 0; a second start at cycle 3 has no effect; with the macro undefined, muldiv_busy stays 0.
REQ-044 Reset mid-op: assert reset_n=0 at BUSY cycle 4 between edges -> muldiv_busy drops immediately and stall_cnt reads 0.
REQ-045 Saturation: with CNT_W=4, hold load_use for 20 cycles -> stall_cnt stops at 15.
